hazard_ctrl_unit: RTL and testbench
===================================

// Module: hazard_ctrl_unit
// PURPOSE
//  Parametrised pipeline hazard controller for the 5-stage core (F/D/E/M/W).
//  Drives per-stage stall/bubble for: trap flush, data-memory wait, multi-cycle MDU wait,
//  branch/jump flush from E, and load-use interlock. Adds an MDU FSM with timeout and
//  saturating performance counters. Sits beside the pipeline registers; outputs are combinational.
// PARAMETERS
//  REG_AW       5   register-index width
//  CNT_W        32  width of each performance counter
//  MDU_MAX_CYC  64  max MDU wait cycles before timeout (>=2)
// PORTS
//  clk                    in   1        core clock, all state on rising edge
//  rst                    in   1        synchronous, active-high reset
//  decode_i_rs1/rs2       in   REG_AW   source regs of instr in D
//  decode_i_rs1_ren/rs2_ren in 1        source reg actually read
//  execute_i_rd           in   REG_AW   dest reg of instr in E
//  execute_i_rd_wen       in   1        instr in E writes rd
//  execute_i_is_load      in   1        instr in E is a load
//  execute_i_is_jump      in   1        taken branch/jump resolved in E
//  execute_i_mdu_start    in   1        MDU op in E (level while op sits in E)
//  execute_i_mdu_done     in   1        MDU result valid this cycle
//  memory_i_busy          in   1        D-mem access in M not complete
//  trap_i_valid           in   1        exception/interrupt committed at W
//  ctrl_o_pc_stall        out  1        hold PC
//  ctrl_o_regD/E/M/W_stall  out 1 each  hold pipeline register
//  ctrl_o_regD/E/M/W_bubble out 1 each  load NOP into pipeline register
//  ctrl_o_mdu_timeout     out  1        one-cycle pulse on MDU timeout
//  ctrl_o_stall_cnt       out  CNT_W    cycles with regD_stall=1
//  ctrl_o_flush_cnt       out  CNT_W    cycles with jump or trap flush
//  ctrl_o_lduse_cnt       out  CNT_W    load-use interlock cycles
// BEHAVIOUR
//  Reset (rst=1): all stalls 0, all four bubbles 1, pc_stall 0; FSM->IDLE, wait cnt=0,
//   timeout 0, all perf counters 0. Stall and bubble never both 1 for the same register.
//  Priority per cycle (first match wins; others masked):
//   1 trap_i_valid: bubble D,E,M,W; no stalls. FSM->IDLE, wait cnt cleared.
//   2 memory_i_busy: stall pc,D,E,M; bubble W.
//   3 mdu_hold: stall pc,D,E; bubble M.
//     mdu_hold = (IDLE & mdu_start & !mdu_done) | (WAIT & !mdu_done).
//   4 execute_i_is_jump: bubble D,E; no stalls.
//   5 load-use: is_load & rd_wen & rd!=0 & ((rs1_ren&rs1==rd)|(rs2_ren&rs2==rd)):
//     stall pc,D; bubble E. Exactly one interlock cycle per hazard.
//   else all 0.
//  Jump under a memory/MDU stall is not flushed; E holds it and it flushes the first
//   unstalled cycle.
//  MDU FSM {IDLE,WAIT}: IDLE->WAIT when mdu_start & !mdu_done & !trap; cnt<=1.
//   In WAIT: done -> IDLE (that cycle unstalled); trap -> IDLE; cnt increments only when
//   memory_i_busy=0; cnt==MDU_MAX_CYC-1 & !done -> timeout pulse next cycle, IDLE, cnt 0.
//   start & done in the same IDLE cycle: no stall, stay IDLE.
//  Counters: +1 per qualifying cycle, saturate at all-ones (no wrap), cleared only by rst.
//  Reset mid-WAIT: immediate abandon, outputs take reset values that same cycle.
// TESTING
//  1 rst=1 two cycles -> all bubbles 1, stalls 0, counters 0; release -> all outputs 0.
//  2 E: load x5, D: add rs1=x5 -> 1 cycle pc/D stall + E bubble; lduse_cnt=1; rd=x0 -> none.
//  3 jump=1 with memory_i_busy=1 for 3 cycles -> 3 cycles pc/D/E/M stall, W bubble, no
//    flush; 4th cycle D/E bubble, flush_cnt=1.
//  4 mdu_start, done after 5 cycles -> 5 stall cycles, M bubble, FSM IDLE; stall_cnt=5.
//  5 MDU_MAX_CYC=4, done never -> timeout pulse exactly once; no stall after timeout.
//  6 trap during WAIT + memory_i_busy -> all four bubbles, no stalls, FSM IDLE; CNT_W=2
//    saturation: 5 flush cycles -> flush_cnt=3.

Source files
------------

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller for the 5-stage F/D/E/M/W core.
// Resolves trap flush, D-mem wait, MDU wait, E-stage jump flush and load-use
// interlock into per-stage stall/bubble controls, tracks the MDU wait with a
// small FSM and timeout, and keeps saturating performance counters.
module hazard_ctrl_unit #(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MDU_MAX_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] decode_i_rs1,
  input  logic [REG_AW-1:0] decode_i_rs2,
  input  logic              decode_i_rs1_ren,
  input  logic              decode_i_rs2_ren,
  input  logic [REG_AW-1:0] execute_i_rd,
  input  logic              execute_i_rd_wen,
  input  logic              execute_i_is_load,
  input  logic              execute_i_is_jump,
  input  logic              execute_i_mdu_start,
  input  logic              execute_i_mdu_done,
  input  logic              memory_i_busy,
  input  logic              trap_i_valid,
  output logic              ctrl_o_pc_stall,
  output logic              ctrl_o_regD_stall,
  output logic              ctrl_o_regE_stall,
  output logic              ctrl_o_regM_stall,
  output logic              ctrl_o_regW_stall,
  output logic              ctrl_o_regD_bubble,
  output logic              ctrl_o_regE_bubble,
  output logic              ctrl_o_regM_bubble,
  output logic              ctrl_o_regW_bubble,
  output logic              ctrl_o_mdu_timeout,
  output logic [CNT_W-1:0]  ctrl_o_stall_cnt,
  output logic [CNT_W-1:0]  ctrl_o_flush_cnt,
  output logic [CNT_W-1:0]  ctrl_o_lduse_cnt
);

  localparam int unsigned WCNT_W = $clog2(MDU_MAX_CYC + 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MDU_MAX_CYC - 1);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } mdu_state_e;

  mdu_state_e        state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;
  logic              lduse_q, lduse_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]  lduse_cnt_q, lduse_cnt_d;

  logic mdu_hold;
  logic load_use;
  logic flush_evt;
  logic lduse_evt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // Hazard detection terms. The op that just timed out is released for one
  // cycle so it can leave E instead of immediately re-arming the FSM.
  always_comb begin
    mdu_hold = ((state_q == ST_IDLE) && execute_i_mdu_start && !execute_i_mdu_done && !timeout_q)
             || ((state_q == ST_WAIT) && !execute_i_mdu_done);
    // A fired interlock bubbles E, so the cycle after it cannot hold the same
    // hazard; masking it guarantees a single interlock cycle per hazard.
    load_use = execute_i_is_load && execute_i_rd_wen && (execute_i_rd != '0) && !lduse_q
             && ((decode_i_rs1_ren && (decode_i_rs1 == execute_i_rd))
              || (decode_i_rs2_ren && (decode_i_rs2 == execute_i_rd)));
  end

  // Priority resolution of stall/bubble controls; reset forces bubbles.
  always_comb begin
    ctrl_o_pc_stall    = 1'b0;
    ctrl_o_regD_stall  = 1'b0;
    ctrl_o_regE_stall  = 1'b0;
    ctrl_o_regM_stall  = 1'b0;
    ctrl_o_regW_stall  = 1'b0;
    ctrl_o_regD_bubble = 1'b0;
    ctrl_o_regE_bubble = 1'b0;
    ctrl_o_regM_bubble = 1'b0;
    ctrl_o_regW_bubble = 1'b0;
    flush_evt          = 1'b0;
    lduse_evt          = 1'b0;
    if (rst) begin
      ctrl_o_regD_bubble = 1'b1;
      ctrl_o_regE_bubble = 1'b1;
      ctrl_o_regM_bubble = 1'b1;
      ctrl_o_regW_bubble = 1'b1;
    end else if (trap_i_valid) begin
      ctrl_o_regD_bubble = 1'b1;
      ctrl_o_regE_bubble = 1'b1;
      ctrl_o_regM_bubble = 1'b1;
      ctrl_o_regW_bubble = 1'b1;
      flush_evt          = 1'b1;
    end else if (memory_i_busy) begin
      ctrl_o_pc_stall    = 1'b1;
      ctrl_o_regD_stall  = 1'b1;
      ctrl_o_regE_stall  = 1'b1;
      ctrl_o_regM_stall  = 1'b1;
      ctrl_o_regW_bubble = 1'b1;
    end else if (mdu_hold) begin
      ctrl_o_pc_stall    = 1'b1;
      ctrl_o_regD_stall  = 1'b1;
      ctrl_o_regE_stall  = 1'b1;
      ctrl_o_regM_bubble = 1'b1;
    end else if (execute_i_is_jump) begin
      ctrl_o_regD_bubble = 1'b1;
      ctrl_o_regE_bubble = 1'b1;
      flush_evt          = 1'b1;
    end else if (load_use) begin
      ctrl_o_pc_stall    = 1'b1;
      ctrl_o_regD_stall  = 1'b1;
      ctrl_o_regE_bubble = 1'b1;
      lduse_evt          = 1'b1;
    end
  end

  // MDU wait FSM next-state, wait counter and timeout pulse.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = 1'b0;
    if (trap_i_valid) begin
      state_d    = ST_IDLE;
      wait_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (execute_i_mdu_start && !execute_i_mdu_done && !timeout_q) begin
            state_d    = ST_WAIT;
            wait_cnt_d = WCNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (execute_i_mdu_done) begin
            state_d    = ST_IDLE;
            wait_cnt_d = '0;
          end else if (wait_cnt_q == WCNT_LAST) begin
            state_d    = ST_IDLE;
            wait_cnt_d = '0;
            timeout_d  = 1'b1;
          end else if (!memory_i_busy) begin
            wait_cnt_d = wait_cnt_q + WCNT_W'(1);
          end
        end
        default: begin
          state_d    = ST_IDLE;
          wait_cnt_d = '0;
        end
      endcase
    end
  end

  // Saturating performance counters and interlock history.
  always_comb begin
    lduse_d     = lduse_evt;
    stall_cnt_d = ctrl_o_regD_stall ? sat_inc(stall_cnt_q) : stall_cnt_q;
    flush_cnt_d = flush_evt ? sat_inc(flush_cnt_q) : flush_cnt_q;
    lduse_cnt_d = lduse_evt ? sat_inc(lduse_cnt_q) : lduse_cnt_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      lduse_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      lduse_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      lduse_q     <= lduse_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      lduse_cnt_q <= lduse_cnt_d;
    end
  end

  // Registered outputs read as reset values while rst is asserted.
  always_comb begin
    ctrl_o_mdu_timeout = timeout_q && !rst;
    ctrl_o_stall_cnt   = rst ? '0 : stall_cnt_q;
    ctrl_o_flush_cnt   = rst ? '0 : flush_cnt_q;
    ctrl_o_lduse_cnt   = rst ? '0 : lduse_cnt_q;
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: a default instance plus a small one
// (MDU_MAX_CYC=4, CNT_W=2) for timeout and counter saturation.
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1, rs2, rd;
  logic       rs1_ren, rs2_ren, rd_wen, is_load, is_jump, mdu_start, mdu_done, mem_busy, trap;

  logic pc, sD, sE, sM, sW, bD, bE, bM, bW, tmo;
  logic [31:0] stall_cnt, flush_cnt, lduse_cnt;
  logic pc_s, sD_s, sE_s, sM_s, sW_s, bD_s, bE_s, bM_s, bW_s, tmo_s;
  logic [1:0] stall_cnt_s, flush_cnt_s, lduse_cnt_s;

  logic [8:0] ctl, ctl_s;
  assign ctl   = {pc, sD, sE, sM, sW, bD, bE, bM, bW};
  assign ctl_s = {pc_s, sD_s, sE_s, sM_s, sW_s, bD_s, bE_s, bM_s, bW_s};

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit dut (
    .clk(clk), .rst(rst),
    .decode_i_rs1(rs1), .decode_i_rs2(rs2),
    .decode_i_rs1_ren(rs1_ren), .decode_i_rs2_ren(rs2_ren),
    .execute_i_rd(rd), .execute_i_rd_wen(rd_wen), .execute_i_is_load(is_load),
    .execute_i_is_jump(is_jump), .execute_i_mdu_start(mdu_start), .execute_i_mdu_done(mdu_done),
    .memory_i_busy(mem_busy), .trap_i_valid(trap),
    .ctrl_o_pc_stall(pc),
    .ctrl_o_regD_stall(sD), .ctrl_o_regE_stall(sE), .ctrl_o_regM_stall(sM), .ctrl_o_regW_stall(sW),
    .ctrl_o_regD_bubble(bD), .ctrl_o_regE_bubble(bE), .ctrl_o_regM_bubble(bM), .ctrl_o_regW_bubble(bW),
    .ctrl_o_mdu_timeout(tmo),
    .ctrl_o_stall_cnt(stall_cnt), .ctrl_o_flush_cnt(flush_cnt), .ctrl_o_lduse_cnt(lduse_cnt)
  );

  hazard_ctrl_unit #(.REG_AW(5), .CNT_W(2), .MDU_MAX_CYC(4)) dut_s (
    .clk(clk), .rst(rst),
    .decode_i_rs1(rs1), .decode_i_rs2(rs2),
    .decode_i_rs1_ren(rs1_ren), .decode_i_rs2_ren(rs2_ren),
    .execute_i_rd(rd), .execute_i_rd_wen(rd_wen), .execute_i_is_load(is_load),
    .execute_i_is_jump(is_jump), .execute_i_mdu_start(mdu_start), .execute_i_mdu_done(mdu_done),
    .memory_i_busy(mem_busy), .trap_i_valid(trap),
    .ctrl_o_pc_stall(pc_s),
    .ctrl_o_regD_stall(sD_s), .ctrl_o_regE_stall(sE_s), .ctrl_o_regM_stall(sM_s), .ctrl_o_regW_stall(sW_s),
    .ctrl_o_regD_bubble(bD_s), .ctrl_o_regE_bubble(bE_s), .ctrl_o_regM_bubble(bM_s), .ctrl_o_regW_bubble(bW_s),
    .ctrl_o_mdu_timeout(tmo_s),
    .ctrl_o_stall_cnt(stall_cnt_s), .ctrl_o_flush_cnt(flush_cnt_s), .ctrl_o_lduse_cnt(lduse_cnt_s)
  );

  // ctl bit order: {pc, sD, sE, sM, sW, bD, bE, bM, bW}
  localparam logic [8:0] C_NONE  = 9'b0_0000_0000;
  localparam logic [8:0] C_RST   = 9'b0_0000_1111;
  localparam logic [8:0] C_TRAP  = 9'b0_0000_1111;
  localparam logic [8:0] C_MEM   = 9'b1_1110_0001;
  localparam logic [8:0] C_MDU   = 9'b1_1100_0010;
  localparam logic [8:0] C_JUMP  = 9'b0_0000_1100;
  localparam logic [8:0] C_LDUSE = 9'b1_1000_0100;

  task automatic idle_inputs();
    rs1 = '0; rs2 = '0; rd = '0;
    rs1_ren = 1'b0; rs2_ren = 1'b0; rd_wen = 1'b0; is_load = 1'b0;
    is_jump = 1'b0; mdu_start = 1'b0; mdu_done = 1'b0; mem_busy = 1'b0; trap = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_total++;
      if (ctl !== C_RST) $display("FAIL reset_ctl[%0d]: got %b want %b", i, ctl, C_RST); else n_pass++;
      n_total++;
      if ({stall_cnt, flush_cnt, lduse_cnt} !== '0 || tmo !== 1'b0)
        $display("FAIL reset_cnt[%0d]: got %0d/%0d/%0d tmo=%b want 0/0/0 tmo=0", i, stall_cnt, flush_cnt, lduse_cnt, tmo);
      else n_pass++;
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    n_total++;
    if (ctl !== C_NONE) $display("FAIL release_ctl: got %b want %b", ctl, C_NONE); else n_pass++;
    @(negedge clk);
    n_total++;
    if ({stall_cnt, flush_cnt, lduse_cnt, tmo} !== '0)
      $display("FAIL release_cnt: got %0d/%0d/%0d tmo=%b want all 0", stall_cnt, flush_cnt, lduse_cnt, tmo);
    else n_pass++;
  endtask

  task automatic test_load_use();
    do_reset();
    is_load = 1'b1; rd_wen = 1'b1; rd = 5'd5; rs1 = 5'd5; rs1_ren = 1'b1;
    #1;
    n_total++;
    if (ctl !== C_LDUSE) $display("FAIL lduse_rs1: got %b want %b", ctl, C_LDUSE); else n_pass++;
    @(negedge clk);
    #1;
    n_total++;
    if (ctl !== C_NONE) $display("FAIL lduse_once: got %b want %b", ctl, C_NONE); else n_pass++;
    @(negedge clk);
    rd = 5'd0; rs1 = 5'd0;
    #1;
    n_total++;
    if (ctl !== C_NONE) $display("FAIL lduse_x0: got %b want %b", ctl, C_NONE); else n_pass++;
    @(negedge clk);
    rd = 5'd9; rs1 = 5'd3; rs2 = 5'd9; rs2_ren = 1'b0;
    #1;
    n_total++;
    if (ctl !== C_NONE) $display("FAIL lduse_noren: got %b want %b", ctl, C_NONE); else n_pass++;
    @(negedge clk);
    rs2_ren = 1'b1;
    #1;
    n_total++;
    if (ctl !== C_LDUSE) $display("FAIL lduse_rs2: got %b want %b", ctl, C_LDUSE); else n_pass++;
    @(negedge clk);
    idle_inputs();
    #1;
    n_total++;
    if (lduse_cnt !== 32'd2 || stall_cnt !== 32'd2)
      $display("FAIL lduse_cnt: got lduse=%0d stall=%0d want 2/2", lduse_cnt, stall_cnt);
    else n_pass++;
  endtask

  task automatic test_jump_under_busy();
    do_reset();
    is_jump = 1'b1; mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++;
      if (ctl !== C_MEM) $display("FAIL jump_busy[%0d]: got %b want %b", i, ctl, C_MEM); else n_pass++;
      @(negedge clk);
    end
    mem_busy = 1'b0;
    #1;
    n_total++;
    if (ctl !== C_JUMP || flush_cnt !== 32'd0)
      $display("FAIL jump_flush: got %b flush=%0d want %b flush=0", ctl, flush_cnt, C_JUMP);
    else n_pass++;
    @(negedge clk);
    idle_inputs();
    #1;
    n_total++;
    if (flush_cnt !== 32'd1 || stall_cnt !== 32'd3)
      $display("FAIL jump_cnt: got flush=%0d stall=%0d want 1/3", flush_cnt, stall_cnt);
    else n_pass++;
  endtask

  task automatic test_mdu_done();
    do_reset();
    mdu_start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_total++;
      if (ctl !== C_MDU) $display("FAIL mdu_wait[%0d]: got %b want %b", i, ctl, C_MDU); else n_pass++;
      @(negedge clk);
    end
    mdu_done = 1'b1;
    #1;
    n_total++;
    if (ctl !== C_NONE) $display("FAIL mdu_done: got %b want %b", ctl, C_NONE); else n_pass++;
    @(negedge clk);
    idle_inputs();
    #1;
    n_total++;
    if (ctl !== C_NONE || stall_cnt !== 32'd5)
      $display("FAIL mdu_after: got %b stall=%0d want %b stall=5", ctl, stall_cnt, C_NONE);
    else n_pass++;
    @(negedge clk);
    mdu_start = 1'b1; mdu_done = 1'b1;
    #1;
    n_total++;
    if (ctl !== C_NONE) $display("FAIL mdu_same_cycle: got %b want %b", ctl, C_NONE); else n_pass++;
    @(negedge clk);
    idle_inputs();
    #1;
    n_total++;
    if (ctl !== C_NONE) $display("FAIL mdu_stay_idle: got %b want %b", ctl, C_NONE); else n_pass++;
  endtask

  task automatic test_timeout();
    int pulses;
    pulses = 0;
    do_reset();
    mdu_start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_total++;
      if (ctl_s !== C_MDU || tmo_s !== 1'b0)
        $display("FAIL tmo_wait[%0d]: got %b tmo=%b want %b tmo=0", i, ctl_s, tmo_s, C_MDU);
      else n_pass++;
      @(negedge clk);
    end
    #1;
    n_total++;
    if (ctl_s !== C_NONE || tmo_s !== 1'b1)
      $display("FAIL tmo_pulse: got %b tmo=%b want %b tmo=1", ctl_s, tmo_s, C_NONE);
    else n_pass++;
    @(negedge clk);
    mdu_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (tmo_s) pulses++;
      n_total++;
      if (ctl_s !== C_NONE) $display("FAIL tmo_after[%0d]: got %b want %b", i, ctl_s, C_NONE); else n_pass++;
      @(negedge clk);
    end
    n_total++;
    if (pulses !== 0) $display("FAIL tmo_once: got %0d extra pulses want 0", pulses); else n_pass++;
  endtask

  task automatic test_trap();
    do_reset();
    mdu_start = 1'b1;
    @(negedge clk);
    mem_busy = 1'b1;
    #1;
    n_total++;
    if (ctl !== C_MEM) $display("FAIL trap_pre_busy: got %b want %b", ctl, C_MEM); else n_pass++;
    @(negedge clk);
    trap = 1'b1;
    #1;
    n_total++;
    if (ctl !== C_TRAP) $display("FAIL trap_flush: got %b want %b", ctl, C_TRAP); else n_pass++;
    @(negedge clk);
    idle_inputs();
    #1;
    n_total++;
    if (ctl !== C_NONE) $display("FAIL trap_fsm_idle: got %b want %b", ctl, C_NONE); else n_pass++;
    do_reset();
    trap = 1'b1;
    for (int i = 0; i < 5; i++) @(negedge clk);
    idle_inputs();
    #1;
    n_total++;
    if (flush_cnt_s !== 2'd3 || flush_cnt !== 32'd5)
      $display("FAIL flush_sat: got small=%0d big=%0d want 3/5", flush_cnt_s, flush_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    mdu_start = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_total++;
    if (ctl !== C_RST) $display("FAIL rst_mid_wait: got %b want %b", ctl, C_RST); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    mdu_start = 1'b0;
    #1;
    n_total++;
    if (ctl !== C_NONE || stall_cnt !== 32'd0)
      $display("FAIL rst_abandon: got %b stall=%0d want %b stall=0", ctl, stall_cnt, C_NONE);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_load_use();
    test_jump_under_busy();
    test_mdu_done();
    test_timeout();
    test_trap();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
